// File: rtl/delay_tap_arbiter.sv
// delay_tap_arbiter: shares the multi-tap delay-line bus among NREQ requesters.
// A round-robin arbiter with bounded grant locking picks one requester per
// cycle and the winner's tap word is registered onto o_Dout.
// Optional build macro ARB_FIXED_PRIO_EN: fixed priority (lowest index wins),
// no rotation pointer; locking and forced release still apply.
module delay_tap_arbiter #(
  parameter int unsigned BITS     = 16,
  parameter int unsigned DELAY    = 4,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAX_LOCK = 3,
  localparam int unsigned TAPW    = (DELAY > 1) ? $clog2(DELAY) : 1,
  localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DELAY*BITS-1:0]  i_Dtaps,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*TAPW-1:0]   i_tap_sel,
  input  logic [NREQ-1:0]        i_lock,
  output logic [NREQ-1:0]        o_gnt,
  output logic [IDW-1:0]         o_gnt_id,
  output logic                   o_valid,
  output logic [BITS-1:0]        o_Dout,
  output logic                   o_err
);

  localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

  logic            owner_vld;
  logic [IDW-1:0]  owner_id;
  logic [LCW-1:0]  lock_cnt;
`ifndef ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nxt_c;
`endif

  logic            hold_c;
  logic [NREQ-1:0] excl_c;
  logic [NREQ-1:0] cand_c;
  logic            win_vld_c;
  logic [IDW-1:0]  win_id_c;
  logic [NREQ-1:0] gnt_c;
  logic [TAPW-1:0] sel_c;
  logic            bad_c;
  logic [BITS-1:0] data_c;
  logic [LCW-1:0]  lock_nxt_c;
  int unsigned     idx_c;

  // Arbitration: lock hold or forced release, then search for the first requester
  always_comb begin
    hold_c    = 1'b0;
    excl_c    = '0;
    win_vld_c = 1'b0;
    win_id_c  = '0;
    idx_c     = 0;
    if (owner_vld && i_req[owner_id] && i_lock[owner_id]) begin
      if (lock_cnt < LCW'(MAX_LOCK)) hold_c = 1'b1;
      else                           excl_c[owner_id] = 1'b1;
    end
    cand_c = i_req & ~excl_c;
    if (hold_c) begin
      win_vld_c = 1'b1;
      win_id_c  = owner_id;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef ARB_FIXED_PRIO_EN
        idx_c = i;
`else
        idx_c = 32'(ptr) + i;
        if (idx_c >= NREQ) idx_c = idx_c - NREQ;
`endif
        if (!win_vld_c && cand_c[idx_c]) begin
          win_vld_c = 1'b1;
          win_id_c  = IDW'(idx_c);
        end
      end
    end
    gnt_c = win_vld_c ? (NREQ'(1) << win_id_c) : '0;
  end

  // Winner's tap word; out-of-range tap index reads as zero and flags an error
  always_comb begin
    sel_c  = '0;
    data_c = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (IDW'(r) == win_id_c) sel_c = i_tap_sel[r*TAPW +: TAPW];
    end
    bad_c = (32'(sel_c) >= DELAY);
    for (int unsigned k = 0; k < DELAY; k++) begin
      if (32'(sel_c) == k) data_c = i_Dtaps[k*BITS +: BITS];
    end
  end

  // Next lock count and rotation pointer
  always_comb begin
    lock_nxt_c = '0;
    if (win_vld_c) lock_nxt_c = hold_c ? lock_cnt + LCW'(1) : LCW'(1);
`ifndef ARB_FIXED_PRIO_EN
    ptr_nxt_c = ptr;
    if (win_vld_c && !hold_c) begin
      ptr_nxt_c = (32'(win_id_c) + 1 >= NREQ) ? '0 : IDW'(32'(win_id_c) + 1);
    end
`endif
  end

  // Arbiter state: owner, lock count, rotation pointer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_vld <= 1'b0;
      owner_id  <= '0;
      lock_cnt  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      owner_vld <= win_vld_c;
      if (win_vld_c) owner_id <= win_id_c;
      lock_cnt  <= lock_nxt_c;
`ifndef ARB_FIXED_PRIO_EN
      ptr       <= ptr_nxt_c;
`endif
    end
  end

  // Registered grant, data and sticky error outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_gnt    <= '0;
      o_gnt_id <= '0;
      o_valid  <= 1'b0;
      o_Dout   <= '0;
      o_err    <= 1'b0;
    end else begin
      o_gnt   <= gnt_c;
      o_valid <= win_vld_c;
      if (win_vld_c) begin
        o_gnt_id <= win_id_c;
        o_Dout   <= data_c;
      end
      if (win_vld_c && bad_c) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_delay_tap_arbiter.sv
// Testbench for delay_tap_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration model. A second instance with DELAY=3
// exercises out-of-range tap selection.
module tb_delay_tap_arbiter;

  localparam int BITS = 16;
  localparam int DELAY = 4;
  localparam int NREQ = 4;
  localparam int MAX_LOCK = 3;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  // Stimulus for the main instance
  logic [15:0] taps[4];
  logic [1:0]  sel[4];
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [63:0] dtaps;
  logic [7:0]  tap_sel;
  assign dtaps   = {taps[3], taps[2], taps[1], taps[0]};
  assign tap_sel = {sel[3], sel[2], sel[1], sel[0]};

  logic [3:0]  o_gnt;
  logic [1:0]  o_gnt_id;
  logic        o_valid;
  logic [15:0] o_Dout;
  logic        o_err;

  // Stimulus for the DELAY=3 instance
  logic [15:0] taps3[3];
  logic [1:0]  sel3[4];
  logic [3:0]  req3;
  logic [47:0] dtaps3;
  logic [7:0]  tap_sel3;
  assign dtaps3   = {taps3[2], taps3[1], taps3[0]};
  assign tap_sel3 = {sel3[3], sel3[2], sel3[1], sel3[0]};

  logic [3:0]  o_gnt3;
  logic [1:0]  o_gnt_id3;
  logic        o_valid3;
  logic [15:0] o_Dout3;
  logic        o_err3;

  delay_tap_arbiter #(.BITS(BITS), .DELAY(DELAY), .NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_Dtaps(dtaps), .i_req(req), .i_tap_sel(tap_sel),
    .i_lock(lock), .o_gnt(o_gnt), .o_gnt_id(o_gnt_id), .o_valid(o_valid),
    .o_Dout(o_Dout), .o_err(o_err)
  );

  delay_tap_arbiter #(.BITS(BITS), .DELAY(3), .NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) u_dut3 (
    .i_clk(i_clk), .i_rst(i_rst), .i_Dtaps(dtaps3), .i_req(req3), .i_tap_sel(tap_sel3),
    .i_lock(4'b0000), .o_gnt(o_gnt3), .o_gnt_id(o_gnt_id3), .o_valid(o_valid3),
    .o_Dout(o_Dout3), .o_err(o_err3)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: arbitration expressed as who-wins rules on integers
  int          m_ptr;
  int          m_owner;
  int          m_cnt;
  logic [3:0]  e_gnt;
  logic [1:0]  e_id;
  logic        e_valid;
  logic [15:0] e_dout;
  logic        e_err;

  wire [23:0] obs   = {o_gnt, o_gnt_id, o_valid, o_Dout, o_err};
  wire [23:0] exp_v = {e_gnt, e_id, e_valid, e_dout, e_err};

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_cnt = 0;
    e_gnt = '0; e_id = '0; e_valid = 1'b0; e_dout = '0; e_err = 1'b0;
  endtask

  task automatic model_step();
    int w = -1;
    int excl = -1;
    bit hold = 1'b0;
    if (m_owner >= 0 && req[m_owner] && lock[m_owner]) begin
      if (m_cnt < MAX_LOCK) hold = 1'b1;
      else excl = m_owner;
    end
    if (hold) w = m_owner;
    else begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = FIXED ? k : (m_ptr + k) % NREQ;
        if (w < 0 && req[c] && c != excl) w = c;
      end
    end
    if (w >= 0) begin
      e_gnt = 4'(1 << w);
      e_id = 2'(w);
      e_valid = 1'b1;
      if (int'(sel[w]) >= DELAY) begin e_dout = '0; e_err = 1'b1; end
      else e_dout = taps[sel[w]];
      if (!hold) m_ptr = (w + 1) % NREQ;
      m_cnt = hold ? m_cnt + 1 : 1;
      m_owner = w;
    end else begin
      e_gnt = '0; e_valid = 1'b0; m_owner = -1; m_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l);
    @(negedge i_clk);
    req = r; lock = l;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; req = '0; lock = '0; req3 = '0;
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== 24'h0 || {o_gnt3, o_gnt_id3, o_valid3, o_Dout3, o_err3} !== 24'h0) begin
      errors++; $display("FAIL reset_values got %h want 000000", obs);
    end
    @(negedge i_clk); i_rst = 1'b0;
    drive(4'b1111, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_pre_grant got %h want %h", obs, exp_v); end
    end
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL reset_mid_valid got %b want 1", o_valid); end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (obs !== 24'h0) begin errors++; $display("FAIL reset_async got %h want 000000", obs); end
    model_reset();
    @(negedge i_clk); i_rst = 1'b0;
    step();
    checks++;
    if (o_gnt_id !== 2'd0 || o_valid !== 1'b1 || obs !== exp_v) begin
      errors++; $display("FAIL reset_first_grant got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_fairness();
    int unsigned ids_a[5] = '{0, 1, 2, 3, 0};
    int unsigned ids_b[3] = '{2, 0, 2};
    do_reset();
    drive(4'b1111, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs !== exp_v || (!FIXED && (o_gnt_id !== 2'(ids_a[i]) || o_valid !== 1'b1))) begin
        errors++; $display("FAIL fairness_all[%0d] got %h want %h id %0d", i, obs, exp_v, ids_a[i]);
      end
    end
    drive(4'b0101, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== exp_v || (!FIXED && o_gnt_id !== 2'(ids_b[i]))) begin
        errors++; $display("FAIL fairness_0101[%0d] got %h want %h id %0d", i, obs, exp_v, ids_b[i]);
      end
    end
  endtask

  task automatic test_datapath();
    do_reset();
    @(negedge i_clk);
    sel[1] = 2'd2; taps[2] = 16'hBEEF; req = 4'b0010; lock = '0;
    step();
    checks++;
    if (o_Dout !== 16'hBEEF || o_gnt !== 4'b0010 || o_valid !== 1'b1 || obs !== exp_v) begin
      errors++; $display("FAIL datapath_grant got %h want %h", obs, exp_v);
    end
    drive(4'b0000, 4'b0000);
    step();
    checks++;
    if (o_valid !== 1'b0 || o_Dout !== 16'hBEEF || o_gnt !== 4'b0000 || obs !== exp_v) begin
      errors++; $display("FAIL datapath_idle got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_lock_cap();
    int unsigned ids[10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
    do_reset();
    drive(4'b1111, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs !== exp_v || (!FIXED && o_gnt_id !== 2'(ids[i]))) begin
        errors++; $display("FAIL lock_cap[%0d] got %h want %h id %0d", i, obs, exp_v, ids[i]);
      end
    end
  endtask

  task automatic test_error();
    do_reset();
    @(negedge i_clk);
    sel3[0] = 2'd3; req3 = 4'b0001;
    step();
    checks++;
    if (o_Dout3 !== 16'h0 || o_valid3 !== 1'b1 || o_err3 !== 1'b1 || o_gnt3 !== 4'b0001) begin
      errors++; $display("FAIL error_bad_tap got d=%h v=%b e=%b want d=0000 v=1 e=1", o_Dout3, o_valid3, o_err3);
    end
    @(negedge i_clk);
    sel3[0] = 2'd1; taps3[1] = 16'h1234;
    step();
    checks++;
    if (o_Dout3 !== 16'h1234 || o_err3 !== 1'b1) begin
      errors++; $display("FAIL error_sticky got d=%h e=%b want d=1234 e=1", o_Dout3, o_err3);
    end
    @(negedge i_clk); req3 = 4'b0000;
    step();
    checks++;
    if (o_err3 !== 1'b1 || o_valid3 !== 1'b0) begin
      errors++; $display("FAIL error_idle got e=%b v=%b want e=1 v=0", o_err3, o_valid3);
    end
    do_reset();
    #1;
    checks++;
    if (o_err3 !== 1'b0) begin errors++; $display("FAIL error_clear got %b want 0", o_err3); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge i_clk);
      req  = 4'($urandom);
      lock = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        taps[k] = 16'($urandom);
        sel[k]  = 2'($urandom);
      end
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random[%0d] req=%b lock=%b got %h want %h", n, req, lock, obs, exp_v);
      end
    end
  endtask

`ifdef ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    drive(4'b1110, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (o_gnt_id !== 2'd1 || o_valid !== 1'b1 || obs !== exp_v) begin
        errors++; $display("FAIL fixed_prio[%0d] got %h want %h", i, obs, exp_v);
      end
    end
  endtask
`endif

  initial begin
    req = '0; lock = '0; req3 = '0;
    for (int k = 0; k < 4; k++) begin taps[k] = '0; sel[k] = '0; sel3[k] = '0; end
    for (int k = 0; k < 3; k++) taps3[k] = '0;
    model_reset();
    #12;
    test_reset();
    test_fairness();
    test_datapath();
    test_lock_cap();
    test_error();
`ifdef ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_tap_arbiter.md
# delay_tap_arbiter

Shares the tap bus of the multi-tap data delay line among NREQ requesters. Each requester names one tap. A round-robin arbiter, with optional bounded grant locking, picks one requester per cycle. The winner's tap word is registered onto a single output port. The block sits directly downstream of the delay line, so consumers (scalers, filters, monitors) read taps without each one needing its own full-width copy of the tap bus.

## Interface
- BITS, 16, width of one tap word
- DELAY, 4, number of taps on i_Dtaps; TAPW = max(1, clog2(DELAY)) is derived as a localparam
- NREQ, 4, number of requesters; IDW = max(1, clog2(NREQ)) is derived as a localparam
- MAX_LOCK, 3, maximum consecutive grants to one locked requester (≥1)
- i_clk  in  1  sole clock; all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_Dtaps  in  DELAY*BITS  tap k at [k*BITS +: BITS], from the delay line
- i_req  in  NREQ  per-requester request, level
- i_tap_sel  in  NREQ*TAPW  requester r's tap index at [r*TAPW +: TAPW]
- i_lock  in  NREQ  requester r asks to keep its grant
- o_gnt  out  NREQ  registered one-hot grant, all-zero when idle
- o_gnt_id  out  IDW  index of last granted requester
- o_valid  out  1  o_Dout holds a fresh word this cycle
- o_Dout  out  BITS  selected tap word
- o_err  out  1  sticky flag: some granted tap index was ≥ DELAY

## Operation
- Arbitration is combinational from i_req, ptr, owner and lock_cnt. All outputs are registered.
- Round-robin search starts at ptr and wraps modulo NREQ. The first asserted i_req wins. After the grant, ptr = winner+1 mod NREQ.
- Lock rule: if owner r was granted last cycle, i_req[r]=1, i_lock[r]=1 and lock_cnt < MAX_LOCK, then r wins again. ptr is unchanged and lock_cnt increments.
- Forced release: when lock_cnt = MAX_LOCK, r is excluded for one arbitration. Normal round-robin proceeds from ptr and lock_cnt resets.
- lock_cnt is 1 on any fresh (non-lock) grant. It is 0 when there is no grant.
- When a winner exists, at the next edge: o_gnt = onehot(w), o_gnt_id = w, o_valid = 1, o_Dout = tap[i_tap_sel[w]] sampled at that edge.
- If the selected tap index is ≥ DELAY: o_Dout = 0, o_err set to 1 and held until reset. The grant is still issued.
- With no requests: o_valid = 0 and o_gnt = 0. o_Dout and o_gnt_id hold. ptr holds, owner is cleared, lock_cnt = 0.
- Deasserting i_req or i_lock by the owner ends the lock immediately. The normal search applies.

## Timing
- Reset values: o_gnt = 0, o_gnt_id = 0, o_valid = 0, o_Dout = 0, o_err = 0, ptr = 0, lock_cnt = 0, owner = none.
- Reset mid-operation clears all outputs asynchronously, without waiting for an edge. The first grant comes on the first rising edge after release with i_req ≠ 0.
- Latency: request sampled at edge n gives grant and data valid after edge n, visible during cycle n+1. Throughput is one grant per cycle.
- i_Dtaps is sampled on the same edge as i_req. The data is therefore the tap contents at the arbitration edge, not one cycle later.
- No ready/backpressure: consumers must take o_Dout in the o_valid cycle.

## Configuration
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest asserted index wins. ptr is not implemented. Lock and MAX_LOCK forced release still apply; on release the next-lowest requester wins.
- Undefined (default): round-robin as described above.

## Test plan
All with BITS = 16, DELAY = 4, NREQ = 4, MAX_LOCK = 3 unless noted.
- Reset: drive i_rst high mid-grant with o_valid = 1 → all outputs 0 before the next edge. After release with i_req = 4'b1111, the first o_gnt_id = 0.
- Fairness: i_req = 4'b1111, i_lock = 0 for 5 cycles → o_gnt_id = 0, 1, 2, 3, 0 with o_valid = 1 each cycle. Then i_req = 4'b0101 → grants alternate 2, 0, 2.
- Data path: i_req = 4'b0010, i_tap_sel[1] = 2, tap2 = 16'hBEEF → next cycle o_Dout = 16'hBEEF, o_gnt = 4'b0010. Then i_req = 0 → o_valid = 0 and o_Dout stays 16'hBEEF.
- Lock cap: i_req = 4'b1111, i_lock = 4'b0001 from reset → o_gnt_id = 0, 0, 0, 1, 2, 3, 0, 0, 0, 1.
- Error: DELAY = 3, TAPW = 2, i_req = 4'b0001, i_tap_sel[0] = 3 → o_Dout = 0, o_valid = 1, o_err = 1. o_err stays 1 after valid selects and clears only on i_rst.
- Fixed priority (ARB_FIXED_PRIO_EN defined): i_req = 4'b1110 held → o_gnt_id = 1 every cycle. With i_lock = 0 there is no rotation.
